// File: rtl/uart_rx_deserializer.sv
// Oversampling UART receiver: 2-flop synchronizer, majority-vote bit sampling,
// false-start rejection and one-cycle valid/break/framing-error strobes.
module uart_rx_deserializer #(
  parameter int unsigned CLOCK_FREQ   = 25000000,
  parameter int unsigned BIT_RATE     = 9600,
  parameter int unsigned PAYLOAD_BITS = 8,
  parameter int unsigned OVERSAMPLE   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rx,
  input  logic                    enable,
  output logic [PAYLOAD_BITS-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    rx_break,
  output logic                    frame_error,
  output logic                    busy
);

  localparam int unsigned TICK_DIV = CLOCK_FREQ / (BIT_RATE * OVERSAMPLE);
  localparam int unsigned Mid      = OVERSAMPLE / 2;
  localparam int unsigned CntW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW       = $clog2(OVERSAMPLE);
  localparam int unsigned BW       = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);
  localparam logic [SW-1:0]   SVoteA  = SW'(Mid - 1);
  localparam logic [SW-1:0]   SVoteB  = SW'(Mid);
  localparam logic [SW-1:0]   SDecide = SW'(Mid + 1);
  localparam logic [SW-1:0]   SLast   = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0]   BitLast = BW'(PAYLOAD_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitIdle
  } state_e;

  state_e                  state_q, state_d;
  logic                    rx_meta_q, rx_s_q;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    tick_q, tick_d;
  logic [SW-1:0]           s_q, s_d;
  logic [BW-1:0]           bit_idx_q, bit_idx_d;
  logic                    samp_a_q, samp_a_d, samp_b_q, samp_b_d;
  logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
  logic [PAYLOAD_BITS-1:0] rx_data_q, rx_data_d;
  logic                    valid_q, valid_d, break_q, break_d, ferr_q, ferr_d;
  logic                    active, vote;
  logic [PAYLOAD_BITS:0]   shift_in;

  assign active = (state_q == StStart) || (state_q == StData) || (state_q == StStop);
  // Third sample is taken live on the decide tick.
  assign vote = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    bit_idx_d = bit_idx_q;
    samp_a_d  = samp_a_q;
    samp_b_d  = samp_b_q;
    shift_d   = shift_q;
    rx_data_d = rx_data_q;
    valid_d   = 1'b0;
    break_d   = 1'b0;
    ferr_d    = 1'b0;
    shift_in  = {vote, shift_q};

    // Tick is registered, so it lands one cycle after the terminal count.
    cnt_d  = (active && (cnt_q != CntLast)) ? cnt_q + 1'b1 : '0;
    tick_d = active && (cnt_q == CntLast);

    if (active && tick_q) begin
      s_d = (s_q == SLast) ? '0 : s_q + 1'b1;
      if (s_q == SVoteA) samp_a_d = rx_s_q;
      if (s_q == SVoteB) samp_b_d = rx_s_q;
    end

    case (state_q)
      StIdle: begin
        s_d       = '0;
        bit_idx_d = '0;
        if (enable && !rx_s_q) state_d = StStart;
      end
      StStart: begin
        if (tick_q) begin
          if ((s_q == SDecide) && vote) begin
            state_d = StIdle;
          end else if (s_q == SLast) begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
      end
      StData: begin
        if (tick_q) begin
          if (s_q == SDecide) shift_d = shift_in[PAYLOAD_BITS:1];
          if (s_q == SLast) begin
            if (bit_idx_q == BitLast) state_d = StStop;
            else bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick_q && (s_q == SDecide)) begin
          if (vote) begin
            rx_data_d = shift_q;
            valid_d   = 1'b1;
            state_d   = StIdle;
          end else if (shift_q == '0) begin
            break_d = 1'b1;
            state_d = StWaitIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end
      end
      StWaitIdle: begin
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      tick_q    <= 1'b0;
      s_q       <= '0;
      bit_idx_q <= '0;
      samp_a_q  <= 1'b0;
      samp_b_q  <= 1'b0;
      shift_q   <= '0;
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      break_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      tick_q    <= tick_d;
      s_q       <= s_d;
      bit_idx_q <= bit_idx_d;
      samp_a_q  <= samp_a_d;
      samp_b_q  <= samp_b_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      valid_q   <= valid_d;
      break_q   <= break_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = valid_q;
  assign rx_break    = break_q;
  assign frame_error = ferr_q;
  // Stays high through the strobe cycle so the frame ends one cycle after it.
  assign busy        = (state_q != StIdle) | valid_q | break_q | ferr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed + randomized bench for uart_rx_deserializer, checked against a
// frame-level model of expected strobes, payloads and strobe timing.
module tb_uart_rx_deserializer;

  localparam int CLK_FREQ  = 768000;
  localparam int BAUD      = 9600;
  localparam int P         = 8;
  localparam int OS        = 16;
  localparam int TD        = CLK_FREQ / (BAUD * OS);
  localparam int M         = OS / 2;
  localparam int BIT_MILLI = TD * OS * 1000;
  // Start edge at pin cycle n: rx_s low at n+2 (T0), stop vote tick
  // k=(P+1)*OS+M+1 at T0+1+(k+1)*TD, strobe one cycle later.
  localparam int LAT       = 2 + 1 + ((P + 1) * OS + M + 2) * TD + 1;
  localparam int KValid = 1, KBreak = 2, KFerr = 3;

  logic         clk = 1'b0, reset = 1'b1, rx = 1'b1, enable = 1'b1;
  logic [P-1:0] rx_data;
  logic         rx_valid, rx_break, frame_error, busy;

  int n_tests = 0, n_fail = 0;
  int cyc = 0, multi = 0, busy_rise = -1, busy_fall = -1;
  logic busy_prev = 1'b0;
  int obs_cyc[$], obs_kind[$], exp_cyc[$], exp_kind[$];
  logic [P-1:0] obs_data[$], exp_data[$];
  logic [P-1:0] last_good = '0;

  int n, e, per;
  logic [P-1:0] d;

  uart_rx_deserializer #(
    .CLOCK_FREQ  (CLK_FREQ),
    .BIT_RATE    (BAUD),
    .PAYLOAD_BITS(P),
    .OVERSAMPLE  (OS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .enable     (enable),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_break   (rx_break),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid || rx_break || frame_error) begin
        obs_cyc.push_back(cyc);
        obs_kind.push_back(rx_valid ? KValid : (rx_break ? KBreak : KFerr));
        obs_data.push_back(rx_data);
      end
      if (int'(rx_valid) + int'(rx_break) + int'(frame_error) > 1) multi <= multi + 1;
      if (busy && !busy_prev) busy_rise <= cyc;
      if (!busy && busy_prev) busy_fall <= cyc;
      busy_prev <= busy;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one frame cycle by cycle from pin cycle n; len>0 truncates it.
  task automatic drive_frame(input logic [P-1:0] data, input bit stop, input int per_milli,
                             input int glitch_at, input int len, input int en_off_at,
                             output int n_o);
    int total;
    total = (len > 0) ? len : ((P + 2) * per_milli + 999) / 1000;
    for (int t = 0; t < total; t++) begin
      int b;
      logic lvl;
      @(posedge clk);
      #1;
      if (t == 0) n_o = cyc;
      b = (t * 1000) / per_milli;
      if (b == 0) lvl = 1'b0;
      else if (b <= P) lvl = data[b-1];
      else lvl = stop;
      if (glitch_at >= 0 && t >= glitch_at && t < glitch_at + TD) lvl = 1'b1;
      if (t == en_off_at) enable = 1'b0;
      rx = lvl;
    end
  endtask

  task automatic idle(input int c);
    repeat (c) begin
      @(posedge clk);
      #1;
      rx = 1'b1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_frame(input logic [P-1:0] data, input bit stop, input int n_i);
    int kind;
    if (stop) begin
      kind = KValid;
      last_good = data;
    end else if (data == '0) begin
      kind = KBreak;
    end else begin
      kind = KFerr;
    end
    exp_cyc.push_back(n_i + LAT);
    exp_kind.push_back(kind);
    exp_data.push_back(last_good);
  endtask

  task automatic compare_events(input string sec);
    check({sec, "_count"}, obs_kind.size(), exp_kind.size());
    for (int i = 0; i < exp_kind.size() && i < obs_kind.size(); i++) begin
      check($sformatf("%s_kind%0d", sec, i), obs_kind[i], exp_kind[i]);
      check($sformatf("%s_data%0d", sec, i), {24'h0, obs_data[i]}, {24'h0, exp_data[i]});
      check($sformatf("%s_cyc%0d", sec, i), obs_cyc[i], exp_cyc[i]);
    end
    obs_cyc.delete(); obs_kind.delete(); obs_data.delete();
    exp_cyc.delete(); exp_kind.delete(); exp_data.delete();
  endtask

  initial begin
    // Reset
    reset = 1'b1;
    rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    check("reset_data", {24'h0, rx_data}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_valid", {31'h0, rx_valid}, 32'h0);
    check("reset_break", {31'h0, rx_break}, 32'h0);
    check("reset_ferr", {31'h0, frame_error}, 32'h0);
    idle(1000);
    compare_events("reset");
    check("reset_busy_after", {31'h0, busy}, 32'h0);

    // Single byte at nominal rate
    drive_frame(8'h55, 1'b1, BIT_MILLI, -1, 0, -1, n);
    expect_frame(8'h55, 1'b1, n);
    idle(20);
    compare_events("single");
    check("single_busy_rise", busy_rise, n + 3);
    check("single_busy_fall", busy_fall, n + LAT + 1);
    check("single_rx_data", {24'h0, rx_data}, 32'h55);

    // False start: 5 ticks low
    drive_frame(8'h00, 1'b1, BIT_MILLI, -1, 5 * TD, -1, n);
    idle(1);
    check("glitch_busy_rise", busy_rise, n + 3);
    wait_until(n + 3 + (M + 2) * TD);
    check("glitch_busy_at_vote", {31'h0, busy}, 32'h1);
    wait_until(n + 4 + (M + 2) * TD);
    check("glitch_busy_after_vote", {31'h0, busy}, 32'h0);
    idle(900);
    compare_events("glitch");

    // One-tick glitch at sample M of data bit 3
    drive_frame(8'h00, 1'b1, BIT_MILLI, (4 * OS + M + 1) * TD, 0, -1, n);
    expect_frame(8'h00, 1'b1, n);
    idle(20);
    compare_events("midglitch");

    // Random back-to-back frames within +/-3% baud error
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      e = int'($urandom_range(0, 60)) - 30;
      per = (BIT_MILLI * 1000) / (1000 + e);
      drive_frame(d, 1'b1, per, -1, 0, -1, n);
      expect_frame(d, 1'b1, n);
    end
    idle(20);
    compare_events("rand");

    // 0xA5 then 0x3C back-to-back at +2.5%
    per = (BIT_MILLI * 1000) / 1025;
    drive_frame(8'hA5, 1'b1, per, -1, 0, -1, n);
    expect_frame(8'hA5, 1'b1, n);
    drive_frame(8'h3C, 1'b1, per, -1, 0, -1, n);
    expect_frame(8'h3C, 1'b1, n);
    idle(20);
    compare_events("skew");

    // enable low blocks detection; dropping it mid-frame does not abort
    drive_frame(8'h5A, 1'b1, BIT_MILLI, -1, 0, 0, n);
    idle(20);
    enable = 1'b1;
    d = 8'($urandom_range(1, 255));
    drive_frame(d, 1'b1, BIT_MILLI, -1, 0, 200, n);
    expect_frame(d, 1'b1, n);
    idle(20);
    enable = 1'b1;
    compare_events("enable");

    // Framing error keeps the previous payload
    drive_frame(8'h81, 1'b0, BIT_MILLI, -1, 0, -1, n);
    expect_frame(8'h81, 1'b0, n);
    idle(20);
    compare_events("ferr");
    check("ferr_busy_idle", {31'h0, busy}, 32'h0);

    // Break: 20 bit times low
    drive_frame(8'h00, 1'b0, BIT_MILLI, -1, 20 * OS * TD, -1, n);
    expect_frame(8'h00, 1'b0, n);
    check("break_busy_low", {31'h0, busy}, 32'h1);
    idle(1);
    check("break_busy_rise_edge", {31'h0, busy}, 32'h1);
    idle(3);
    check("break_busy_released", {31'h0, busy}, 32'h0);
    idle(20);
    compare_events("break");

    // Reset during data bit 4
    d = 8'($urandom_range(0, 255));
    drive_frame(d, 1'b1, BIT_MILLI, -1, 4 * OS * TD + OS * TD / 2, -1, n);
    check("midreset_busy_before", {31'h0, busy}, 32'h1);
    reset = 1'b1;
    rx = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    last_good = '0;
    check("midreset_busy", {31'h0, busy}, 32'h0);
    check("midreset_data", {24'h0, rx_data}, 32'h0);
    idle(900);
    compare_events("midreset");

    check("strobe_onehot", multi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
